// File: rtl/rob_tag_retire.sv
// rtl/rob_tag_retire.sv - N-way reorder buffer tracking rename tags through dispatch, completion, retire and squash
// Defining ROB_RETIRE_CNT_EN adds the free-running retire_total output.
module rob_tag_retire #(
  parameter int N_WAY    = 2,
  parameter int N_ROB    = 16,
  parameter int TAG_BITS = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [$clog2(N_WAY):0]         dispatch_num,
  input  logic [N_WAY-1:0][TAG_BITS-1:0] disp_t,
  input  logic [N_WAY-1:0][TAG_BITS-1:0] disp_told,
  output logic [N_WAY-1:0]               dispatched,
  input  logic [N_WAY-1:0]               cdb_valid,
  input  logic [N_WAY-1:0][TAG_BITS-1:0] cdb_tag,
  input  logic                           branch_haz,
  input  logic [$clog2(N_ROB)-1:0]       branch_idx,
  output logic [N_WAY-1:0][TAG_BITS-1:0] rob_told,
  output logic [$clog2(N_WAY):0]         retire_num,
  output logic [N_ROB-1:0][TAG_BITS-1:0] free_list_haz,
  output logic [$clog2(N_ROB):0]         rob_count
`ifdef ROB_RETIRE_CNT_EN
  ,
  output logic [31:0]                    retire_total
`endif
);

  localparam int DW = $clog2(N_WAY) + 1;
  localparam int IW = $clog2(N_ROB);
  localparam int CW = IW + 1;

  logic [N_ROB-1:0]                valid_q;
  logic [N_ROB-1:0]                complete_q;
  logic [N_ROB-1:0][TAG_BITS-1:0]  t_q;
  logic [N_ROB-1:0][TAG_BITS-1:0]  told_q;
  logic [IW-1:0]                   head_q;
  logic [IW-1:0]                   tail_q;
  logic [CW-1:0]                   count_q;

  logic [CW-1:0]                   free_slots;
  logic [DW-1:0]                   disp_cnt;
  logic [DW-1:0]                   ret_cnt;
  logic                            ret_stop;
  logic [N_WAY-1:0][TAG_BITS-1:0]  ret_told;
  logic [IW-1:0]                   br_age;
  logic                            br_live;
  logic [N_ROB-1:0]                squash;
  logic [N_ROB-1:0][TAG_BITS-1:0]  squash_tags;
  logic [IW-1:0]                   sq_pos;
  logic [N_ROB-1:0]                valid_n;
  logic [N_ROB-1:0]                complete_n;
  logic [CW-1:0]                   count_n;
  logic [IW-1:0]                   tail_n;

  assign rob_count = count_q;

  // Free space comes from the registered count, so slots freed by this cycle's retire stay unusable.
  always_comb begin
    free_slots = CW'(N_ROB) - count_q;
    dispatched = '0;
    disp_cnt   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!branch_haz && (DW'(i) < dispatch_num) && (CW'(i) < free_slots)) begin
        dispatched[i] = 1'b1;
        disp_cnt      = disp_cnt + DW'(1);
      end
    end
  end

  // Ages are measured from head; the branch bounds retire and everything older than it survives.
  always_comb begin
    br_age   = branch_idx - head_q;
    br_live  = branch_haz && ({1'b0, br_age} < count_q);
    ret_cnt  = '0;
    ret_told = '0;
    ret_stop = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!ret_stop && (!branch_haz || (IW'(i) <= br_age)) &&
          valid_q[head_q + IW'(i)] && complete_q[head_q + IW'(i)]) begin
        ret_told[i] = told_q[head_q + IW'(i)];
        ret_cnt     = ret_cnt + DW'(1);
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  // Walk in age order so squashed tags pack oldest-first from slot 0.
  always_comb begin
    squash      = '0;
    squash_tags = '0;
    sq_pos      = '0;
    for (int a = 0; a < N_ROB; a++) begin
      if (br_live && (IW'(a) > br_age) && (CW'(a) < count_q)) begin
        squash[head_q + IW'(a)] = 1'b1;
        squash_tags[sq_pos]     = t_q[head_q + IW'(a)];
        sq_pos                  = sq_pos + IW'(1);
      end
    end
  end

  always_comb begin
    valid_n    = valid_q & ~squash;
    complete_n = complete_q;
    for (int j = 0; j < N_ROB; j++) begin
      for (int k = 0; k < N_WAY; k++) begin
        if (cdb_valid[k] && (cdb_tag[k] != '0) && valid_n[j] && (t_q[j] == cdb_tag[k])) begin
          complete_n[j] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_cnt > DW'(i)) begin
        valid_n[head_q + IW'(i)] = 1'b0;
      end
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (dispatched[i]) begin
        valid_n[tail_q + IW'(i)]    = 1'b1;
        complete_n[tail_q + IW'(i)] = 1'b0;
      end
    end
    if (br_live) begin
      count_n = {1'b0, br_age} + CW'(1) - CW'(ret_cnt);
      tail_n  = branch_idx + IW'(1);
    end else begin
      count_n = count_q + CW'(disp_cnt) - CW'(ret_cnt);
      tail_n  = tail_q + IW'(disp_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= '0;
      complete_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rob_told      <= '0;
      retire_num    <= '0;
      free_list_haz <= '0;
    end else begin
      valid_q       <= valid_n;
      complete_q    <= complete_n;
      head_q        <= head_q + IW'(ret_cnt);
      tail_q        <= tail_n;
      count_q       <= count_n;
      rob_told      <= ret_told;
      retire_num    <= ret_cnt;
      free_list_haz <= squash_tags;
    end
  end

  // Tag payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (dispatched[i]) begin
        t_q[tail_q + IW'(i)]    <= disp_t[i];
        told_q[tail_q + IW'(i)] <= disp_told[i];
      end
    end
  end

`ifdef ROB_RETIRE_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_total <= '0;
    end else begin
      retire_total <= retire_total + 32'(retire_num);
    end
  end
`endif

endmodule

// File: tb/tb_rob_tag_retire.sv
// tb/tb_rob_tag_retire.sv - directed scoreboard bench for rob_tag_retire
module tb_rob_tag_retire;
  localparam int N_WAY    = 2;
  localparam int N_ROB    = 16;
  localparam int TAG_BITS = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0]                     dispatch_num;
  logic [N_WAY-1:0][TAG_BITS-1:0] disp_t;
  logic [N_WAY-1:0][TAG_BITS-1:0] disp_told;
  logic [N_WAY-1:0]               dispatched;
  logic [N_WAY-1:0]               cdb_valid;
  logic [N_WAY-1:0][TAG_BITS-1:0] cdb_tag;
  logic                           branch_haz;
  logic [3:0]                     branch_idx;
  logic [N_WAY-1:0][TAG_BITS-1:0] rob_told;
  logic [1:0]                     retire_num;
  logic [N_ROB-1:0][TAG_BITS-1:0] free_list_haz;
  logic [4:0]                     rob_count;
`ifdef ROB_RETIRE_CNT_EN
  logic [31:0]                    retire_total;
`endif

  int checks        = 0;
  int failures      = 0;
  int retired_model = 0;
  logic [TAG_BITS-1:0]            sb_q[$];
  logic [N_ROB-1:0][TAG_BITS-1:0] fl_exp;

  rob_tag_retire #(.N_WAY(N_WAY), .N_ROB(N_ROB), .TAG_BITS(TAG_BITS)) dut (
    .clock(clock), .reset(reset), .dispatch_num(dispatch_num), .disp_t(disp_t),
    .disp_told(disp_told), .dispatched(dispatched), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .branch_haz(branch_haz), .branch_idx(branch_idx), .rob_told(rob_told),
    .retire_num(retire_num), .free_list_haz(free_list_haz), .rob_count(rob_count)
`ifdef ROB_RETIRE_CNT_EN
    , .retire_total(retire_total)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    dispatch_num = '0;
    disp_t       = '0;
    disp_told    = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    branch_haz   = 1'b0;
    branch_idx   = '0;
  endtask

  // One clock; retired T_old values are popped from the scoreboard in slot order.
  task automatic tick();
    logic [TAG_BITS-1:0] exp_t;
    @(posedge clock);
    #1;
    for (int i = 0; i < N_WAY; i++) begin
      if (i < int'(retire_num)) begin
        exp_t = '0;
        if (sb_q.size() > 0) exp_t = sb_q.pop_front();
        retired_model++;
        check("rob_told_retired", rob_told[i], exp_t);
      end else begin
        check("rob_told_unused", rob_told[i], 0);
      end
    end
    clear_inputs();
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [5:0] a, input logic [5:0] b);
    cdb_valid  = v;
    cdb_tag[0] = a;
    cdb_tag[1] = b;
  endtask

  task automatic dispatch(input int n, input logic [5:0] t0, input logic [5:0] t1,
                          input logic [5:0] o0, input logic [5:0] o1, input logic [1:0] exp_mask);
    dispatch_num = 2'(n);
    disp_t[0]    = t0;
    disp_t[1]    = t1;
    disp_told[0] = o0;
    disp_told[1] = o1;
    #1;
    check("dispatched", dispatched, exp_mask);
    if (exp_mask[0]) sb_q.push_back(o0);
    if (exp_mask[1]) sb_q.push_back(o1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    retired_model = 0;
    check("reset_count", rob_count, 0);
    check("reset_retire_num", retire_num, 0);
    check("reset_free_list", free_list_haz, 0);
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (rob_count == 0) break;
      tick();
    end
    check("drain_empty", rob_count, 0);
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // dual dispatch, dual completion, dual retire
    dispatch(2, 33, 34, 1, 2, 2'b11);
    check("count_after_disp", rob_count, 2);
    set_cdb(2'b11, 33, 34);
    tick();
    check("retire_pending", retire_num, 0);
    tick();
    check("retire_pair", retire_num, 2);
    check("count_drained", rob_count, 0);
    dispatch(1, 35, 0, 3, 0, 2'b01);
    set_cdb(2'b01, 35, 0);
    tick();
    tick();
    check("retire_single", retire_num, 1);
    tick();
    check("retire_empty", retire_num, 0);

    // fill to full, then retire frees space for the following cycle only
    do_reset();
    for (int k = 0; k < 7; k++)
      dispatch(2, 6'(16 + 2 * k), 6'(17 + 2 * k), 6'(2 * k + 1), 6'(2 * k + 2), 2'b11);
    dispatch(1, 30, 0, 15, 0, 2'b01);
    dispatch(2, 31, 62, 16, 0, 2'b01);
    check("count_full", rob_count, 16);
    dispatch(2, 40, 41, 50, 51, 2'b00);
    set_cdb(2'b11, 16, 17);
    dispatch(2, 40, 41, 50, 51, 2'b00);
    dispatch(2, 40, 41, 50, 51, 2'b00);
    check("retire_from_full", retire_num, 2);
    check("count_after_free", rob_count, 14);
    dispatch(2, 40, 41, 50, 51, 2'b11);
    check("count_refull", rob_count, 16);

    // in-order retire blocked by an incomplete head
    do_reset();
    dispatch(2, 50, 51, 3, 4, 2'b11);
    dispatch(2, 52, 53, 5, 6, 2'b11);
    set_cdb(2'b01, 51, 0);
    tick();
    tick();
    check("retire_blocked", retire_num, 0);
    tick();
    check("retire_blocked2", retire_num, 0);
    set_cdb(2'b01, 50, 0);
    tick();
    tick();
    check("retire_after_head", retire_num, 2);
    check("count_two_left", rob_count, 2);

    // branch squash of entries 3..5, tail rewinds to 3
    do_reset();
    dispatch(2, 40, 41, 7, 8, 2'b11);
    dispatch(2, 42, 43, 9, 10, 2'b11);
    dispatch(2, 44, 45, 11, 12, 2'b11);
    set_cdb(2'b11, 40, 44);
    branch_haz = 1'b1;
    branch_idx = 4'd2;
    dispatch(2, 50, 51, 20, 21, 2'b00);
    fl_exp    = '0;
    fl_exp[0] = 43;
    fl_exp[1] = 44;
    fl_exp[2] = 45;
    check("free_list_squash", free_list_haz, fl_exp);
    check("count_after_squash", rob_count, 3);
    repeat (3) sb_q.delete(sb_q.size() - 1);
    dispatch(2, 46, 47, 13, 14, 2'b11);
    check("free_list_cleared", free_list_haz, 0);
    check("retire_partial", retire_num, 1);
    check("count_post_squash", rob_count, 4);
    set_cdb(2'b11, 41, 42);
    tick();
    set_cdb(2'b11, 46, 47);
    tick();
    drain(10);

    // walk head/tail to 14, then wrap across the end of the buffer
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) set_cdb(2'b11, 6'(18 + 2 * k), 6'(19 + 2 * k));
      dispatch(2, 6'(20 + 2 * k), 6'(21 + 2 * k), 6'(2 * k + 1), 6'(2 * k + 2), 2'b11);
    end
    set_cdb(2'b11, 32, 33);
    tick();
    drain(20);
    dispatch(2, 60, 61, 40, 41, 2'b11);
    dispatch(2, 62, 63, 42, 43, 2'b11);
    check("count_wrapped", rob_count, 4);
    set_cdb(2'b11, 60, 61);
    tick();
    set_cdb(2'b11, 62, 63);
    tick();
    drain(10);
    check("sb_empty_wrap", sb_q.size(), 0);
    tick();
`ifdef ROB_RETIRE_CNT_EN
    check("retire_total", retire_total, retired_model);
`endif

    // reset with five completed entries pending retire
    dispatch(2, 10, 11, 21, 22, 2'b11);
    dispatch(2, 12, 13, 23, 24, 2'b11);
    dispatch(1, 14, 0, 25, 0, 2'b01);
    set_cdb(2'b11, 11, 12);
    tick();
    set_cdb(2'b11, 13, 14);
    tick();
    set_cdb(2'b01, 10, 0);
    tick();
    check("count_five", rob_count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("midreset_retire_num", retire_num, 0);
    check("midreset_rob_told", rob_told, 0);
    check("midreset_count", rob_count, 0);
    check("midreset_free_list", free_list_haz, 0);
    tick();
    tick();
    check("post_reset_retire", retire_num, 0);
    check("post_reset_count", rob_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_tag_retire.md
ROB_TAG_RETIRE -- requirements
Module: rob_tag_retire

Interface
REQ-001 SHALL have parameter N_WAY, default 2, dispatch/retire/complete width.
REQ-002 SHALL have parameter N_ROB, default 16 (power of two), entry count.
REQ-003 SHALL have parameter TAG_BITS, default 6, physical tag width; tag 0 = null.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 dispatch_num  input  clog2(N_WAY)+1  count of slots requesting dispatch, slots 0..dispatch_num-1.
REQ-007 disp_t  input  N_WAY x TAG_BITS  new tag T per slot.
REQ-008 disp_told  input  N_WAY x TAG_BITS  previous mapping T_old per slot.
REQ-009 dispatched  output  N_WAY  per-slot accept, combinational.
REQ-010 cdb_valid  input  N_WAY  completion broadcast valid.
REQ-011 cdb_tag  input  N_WAY x TAG_BITS  completing tag.
REQ-012 branch_haz  input  1  mispredict squash request.
REQ-013 branch_idx  input  clog2(N_ROB)  entry index of mispredicted branch.
REQ-014 rob_told  output  N_WAY x TAG_BITS  T_old of retired entries, registered.
REQ-015 retire_num  output  clog2(N_WAY)+1  entries retired last cycle, registered.
REQ-016 free_list_haz  output  N_ROB x TAG_BITS  T of squashed entries, registered.
REQ-017 rob_count  output  clog2(N_ROB)+1  occupied entries, registered.

Function
REQ-018 SHALL hold a circular buffer of N_ROB entries {valid, complete, T, T_old} with head, tail, count.
REQ-019 dispatched[i] SHALL be 1 iff i<dispatch_num, i<(N_ROB-rob_count), branch_haz=0.
REQ-020 accepted slots SHALL be written in slot order at tail, complete=0; tail advances modulo N_ROB next edge.
REQ-021 cdb_valid[k] SHALL set complete on every valid entry with T==cdb_tag[k], effective next cycle; tag 0 ignored.
REQ-022 Retire SHALL take up to N_WAY contiguous oldest entries with complete=1, stopping at first incomplete entry.
REQ-023 rob_told[i] SHALL equal T_old of i-th retired entry the cycle after retire, 0 for unused slots; retire_num matches.
REQ-024 On branch_haz, all valid entries younger than branch_idx SHALL be invalidated; tail <= branch_idx+1 mod N_ROB.
REQ-025 Squashed T tags SHALL appear in free_list_haz, one per slot, packed from slot 0, zero elsewhere, for exactly the next cycle; zero in all other cycles.
REQ-026 Retire in the branch_haz cycle SHALL proceed but never include entries younger than branch_idx.
REQ-027 Space freed by retire SHALL NOT be usable by dispatch in the same cycle.
REQ-028 Completion for an entry squashed in the same cycle SHALL be dropped.
REQ-029 Full (rob_count=N_ROB): all dispatched=0; empty: retire_num=0, rob_told all 0.
REQ-030 Pointers SHALL wrap from N_ROB-1 to 0 with no lost or duplicated entry.

Reset
REQ-031 reset SHALL clear all valid/complete bits, head=tail=0, rob_count=0, rob_told=0, retire_num=0, free_list_haz=0.
REQ-032 reset mid-operation SHALL discard all entries with no tag emitted on rob_told or free_list_haz.

Configuration
REQ-033 ROB_RETIRE_CNT_EN defined: SHALL add output retire_total [31:0], cleared on reset, incremented by retire_num each cycle, wrapping at 2^32.
REQ-034 ROB_RETIRE_CNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification (N_WAY=2, N_ROB=16)
REQ-035 reset, dispatch_num=2, T={33,34}, T_old={1,2}, cdb both -> dispatched=2'b11; after completion, rob_told={1,2}, retire_num=2.
REQ-036 fill 16 entries, dispatch_num=2 -> dispatched=0, rob_count=16; retire 2 -> dispatch accepted one cycle later.
REQ-037 entries 0..3 valid, complete only entry 1 -> retire_num=0; then complete entry 0 -> rob_told={T_old0,T_old1}.
REQ-038 entries 0..5 with T=40..45, branch_haz, branch_idx=2 -> next cycle free_list_haz slots 0..2={43,44,45}, rest 0; rob_count=3.
REQ-039 head=tail=14, dispatch 4 over two cycles, complete all -> retire order entries 14,15,0,1.
REQ-040 reset asserted with 5 complete entries -> rob_told=0, retire_num=0, rob_count=0 next cycle.
